uart_transmitter: RTL and testbench
===================================

# uart_transmitter

Serial transmit controller that sequences one UART frame per accepted byte: start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. It is timed entirely by the 16× oversampling tick from the baud rate generator. It sits between the host-side TX buffer (valid/ready handshake) and the TX pin.

## Interface
- No parameters. Oversampling factor fixed at 16.
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- ov_baud_rt_i  in  1  one-cycle 16× baud tick from baud_rate_generator
- data_i  in  8  byte to send; bits above the selected width ignored
- data_width_i  in  2  data bits: 00=5, 01=6, 10=7, 11=8
- parity_en_i  in  1  1 = parity bit inserted
- parity_odd_i  in  1  1 = odd parity, 0 = even parity
- stop_bits_i  in  1  0 = one stop bit, 1 = two stop bits
- tx_valid_i  in  1  host offers data_i plus config
- tx_ready_o  out  1  high only in IDLE; transfer when tx_valid_i & tx_ready_o
- tx_o  out  1  serial line, idle high
- busy_o  out  1  high in every state except IDLE
- tx_done_o  out  1  one-cycle pulse when the last stop bit completes

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_o=1, tx_ready_o=1. On handshake, latch data_i (masked to width), data_width_i, parity_en_i, parity_odd_i, stop_bits_i, clear tick_cnt, then go to START. Config inputs are ignored while busy.
- Bit timing: a 4-bit tick_cnt increments on each ov_baud_rt_i. A bit ends on the tick where tick_cnt==15; tick_cnt then wraps to 0. Each bit therefore spans exactly 16 ov ticks.
- START: tx_o=0. After 16 ticks, go to DATA with bit_idx=0.
- DATA: tx_o = shift_reg[0]; shift right at each bit end. After bit_idx == width-1 completes, go to PARITY if parity is enabled, otherwise STOP.
- Parity bit: XOR of the latched masked data bits, inverted when odd parity is selected. It is computed at the handshake and held in a register.
- PARITY: tx_o = parity bit for 16 ticks, then go to STOP.
- STOP: tx_o=1 for 16 ticks (one stop bit) or 32 ticks (two stop bits, using a stop counter). At the end, assert tx_done_o for one cycle and return to IDLE.
- tx_o is registered, so there are no glitches on the pin.

## Timing
- Reset values: tx_o=1, tx_ready_o=1, busy_o=0, tx_done_o=0, state=IDLE, all counters 0.
- Reset asserted mid-frame: tx_o returns high asynchronously and the frame is abandoned; tx_done_o is not pulsed.
- Handshake at edge N: tx_o=0, busy_o=1, tx_ready_o=0 from edge N+1.
- With divisor D, one bit lasts from 15·(D+1)+1 to 16·(D+1) clocks. The first bit is shortened only by tick phase alignment; all following bits last exactly 16·(D+1) clocks.
- tx_done_o asserts together with the return to IDLE (tx_ready_o=1 in that same cycle). A new handshake in that cycle starts the next frame with zero idle gap beyond the stop bit(s).
- If ov_baud_rt_i is asserted in the handshake cycle, it is not counted.
- Frame length in bit periods = 1 + width + parity_en + (1 or 2). Range is 7 to 12.
- If ov_baud_rt_i stays low, the FSM holds its state indefinitely. This is legal and not an error.

## Structure
- Shared package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - data width encodings and constant OVERSAMPLE=16
  - stop bit encodings
  - these are reused by the future receiver.
- The block has no sub-module: one FSM plus tick_cnt, bit_idx, stop counter, shift register, and parity register.
- baud_rate_generator is instantiated alongside this block at top level, not inside it.

## Test plan
- 8N1, data 0x55, divisor 0: tx_o sequence 0,1,0,1,0,1,0,1,0,1 with each bit lasting 16 clocks. tx_done_o pulses once, then tx_ready_o=1.
- 7E1, data 0xFF: only 7 data bits (all 1) are sent. Even parity bit = 1 and bit 7 is not transmitted. Total frame = 10 bit periods.
- 5O2, data 0x03: data 1,1,0,0,0; odd parity bit = 1; stop held high for 32 ticks. busy_o is high for 9 bit periods.
- Back-to-back: hold tx_valid_i high with 0xA5 then 0x3C. The second start bit begins on the clock right after tx_done_o, with no extra idle.
- Config change mid-frame: flip data_width_i, parity_en_i, and stop_bits_i during DATA. The current frame is unaffected and the next frame uses the new values.
- Reset asserted in the middle of the DATA bit with ov_baud_rt_i stalled: tx_o=1 immediately, no tx_done_o, and the next handshake sends a full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, data-width and stop-bit encodings, oversampling factor.
// Reused by the transmitter now and the receiver later; holds no logic of its own.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    DW_5 = 2'b00,
    DW_6 = 2'b01,
    DW_7 = 2'b10,
    DW_8 = 2'b11
  } data_width_t;

  typedef enum logic {
    STOP_1 = 1'b0,
    STOP_2 = 1'b1
  } stop_bits_t;

  function automatic logic [7:0] data_mask(input data_width_t w);
    logic [7:0] m;
    case (w)
      DW_5:    m = 8'h1F;
      DW_6:    m = 8'h3F;
      DW_7:    m = 8'h7F;
      DW_8:    m = 8'hFF;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // Index of the final data bit: 4 for 5-bit words up to 7 for 8-bit words.
  function automatic logic [2:0] last_bit_idx(input data_width_t w);
    return 3'd4 + {1'b0, w};
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Host/baud-side signal bundle of the UART transmitter; master = host + baud generator, slave = transmitter.
// Handshake is valid/ready; names carry the transmitter-relative _i/_o direction.
interface uart_transmitter_if;

  logic       ov_baud_rt_i;
  logic [7:0] data_i;
  logic [1:0] data_width_i;
  logic       parity_en_i;
  logic       parity_odd_i;
  logic       stop_bits_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       tx_o;
  logic       busy_o;
  logic       tx_done_o;

  modport master (
    output ov_baud_rt_i, data_i, data_width_i, parity_en_i, parity_odd_i,
           stop_bits_i, tx_valid_i,
    input  tx_ready_o, tx_o, busy_o, tx_done_o
  );

  modport slave (
    input  ov_baud_rt_i, data_i, data_width_i, parity_en_i, parity_odd_i,
           stop_bits_i, tx_valid_i,
    output tx_ready_o, tx_o, busy_o, tx_done_o
  );

endinterface

// File: rtl/uart_transmitter.sv
// UART frame sequencer: start, 5-8 data bits LSB first, optional parity, 1-2 stop bits, 16 ov ticks per bit.
// Pin goes low the cycle after handshake; ready only in IDLE, so the host is stalled for the whole frame.
module uart_transmitter
  import uart_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_n_i,
  uart_transmitter_if.slave bus
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  tx_state_t   state_q,    state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic [7:0]  shift_q,    shift_d;
  logic        parity_q,   parity_d;
  data_width_t width_q,    width_d;
  logic        par_en_q,   par_en_d;
  stop_bits_t  stop_q,     stop_d;
  logic        tx_q,       tx_d;
  logic        done_q,     done_d;

  logic        handshake;
  logic        bit_end;
  data_width_t in_width;
  logic [7:0]  in_masked;

  assign in_width  = data_width_t'(bus.data_width_i);
  assign in_masked = bus.data_i & data_mask(in_width);
  assign handshake = bus.tx_valid_i & (state_q == IDLE);
  assign bit_end   = bus.ov_baud_rt_i & (state_q != IDLE) & (tick_cnt_q == TICK_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    width_d    = width_q;
    par_en_d   = par_en_q;
    stop_d     = stop_q;
    done_d     = 1'b0;
    tx_d       = 1'b1;

    // Ticks only advance the counter once a frame is underway, so a tick
    // coinciding with the handshake is not counted.
    if ((state_q != IDLE) && bus.ov_baud_rt_i) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (handshake) begin
          shift_d    = in_masked;
          parity_d   = (^in_masked) ^ bus.parity_odd_i;
          width_d    = in_width;
          par_en_d   = bus.parity_en_i;
          stop_d     = stop_bits_t'(bus.stop_bits_i);
          tick_cnt_d = 4'd0;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == last_bit_idx(width_q)) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if ((stop_q == STOP_2) && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            stop_cnt_d = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Pin level is decoded from the next state so the registered output
    // lines up with the state it belongs to.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      tick_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shift_q    <= 8'd0;
      parity_q   <= 1'b0;
      width_q    <= DW_8;
      par_en_q   <= 1'b0;
      stop_q     <= STOP_1;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      width_q    <= width_d;
      par_en_q   <= par_en_d;
      stop_q     <= stop_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx_o       = tx_q;
  assign bus.tx_done_o  = done_q;
  assign bus.tx_ready_o = (state_q == IDLE);
  assign bus.busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: expected pin level is frame[ticks_since_handshake / 16] built from the frame rules.
module tb_uart_transmitter;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  uart_transmitter_if bus ();

  uart_transmitter dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tx_valid_i   = 1'b0;
      bus.ov_baud_rt_i = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_tx", bus.tx_o, 1'b1);
      chk("idle_ready", bus.tx_ready_o, 1'b1);
      chk("idle_done", bus.tx_done_o, 1'b0);
    end
  endtask

  // Starts in an IDLE cycle (#1 after an edge); returns in the cycle after the
  // final stop tick, i.e. the tx_done_o cycle, so a following call chains with no gap.
  task automatic run_frame(input logic [7:0] d, input logic [1:0] dw, input logic pe,
                           input logic po, input logic sb, input int div, input int abort_at);
    logic fr [0:11];
    int   len;
    int   nd;
    int   ones;
    int   t;
    int   ph;
    logic ovn;
    logic expb;

    nd   = 5 + int'(dw);
    fr[0] = 1'b0;
    len  = 1;
    ones = 0;
    for (int i = 0; i < nd; i++) begin
      fr[len] = d[i];
      ones    = ones + int'(d[i]);
      len++;
    end
    if (pe) begin
      fr[len] = ((ones % 2) == 1) ^ po;
      len++;
    end
    fr[len] = 1'b1;
    len++;
    if (sb) begin
      fr[len] = 1'b1;
      len++;
    end

    bus.data_i       = d;
    bus.data_width_i = dw;
    bus.parity_en_i  = pe;
    bus.parity_odd_i = po;
    bus.stop_bits_i  = sb;
    bus.tx_valid_i   = 1'b1;
    bus.ov_baud_rt_i = 1'($urandom);
    chk("hs_ready", bus.tx_ready_o, 1'b1);
    @(posedge clk); #1;

    t  = 0;
    ph = $urandom_range(0, div);
    // First check also covers the "tx_o=0, busy_o=1, ready=0 right after handshake" rule.
    chk("start_tx", bus.tx_o, 1'b0);
    chk("start_busy", bus.busy_o, 1'b1);
    chk("start_ready", bus.tx_ready_o, 1'b0);

    while (t < 16 * len) begin
      ovn = (ph == div);
      ph  = ovn ? 0 : ph + 1;
      bus.ov_baud_rt_i = ovn;
      bus.tx_valid_i   = 1'b0;
      bus.data_i       = 8'($urandom);
      bus.data_width_i = 2'($urandom);
      bus.parity_en_i  = 1'($urandom);
      bus.parity_odd_i = 1'($urandom);
      bus.stop_bits_i  = 1'($urandom);
      @(posedge clk); #1;
      if (ovn) t++;
      expb = (t < 16 * len) ? fr[t / 16] : 1'b1;
      chk("tx", bus.tx_o, expb);
      chk("busy", bus.busy_o, (t < 16 * len));
      chk("ready", bus.tx_ready_o, (t >= 16 * len));
      chk("done", bus.tx_done_o, (t == 16 * len));

      if ((abort_at != 0) && (t == abort_at)) begin
        bus.ov_baud_rt_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(posedge clk); #1;
          chk("stall_tx", bus.tx_o, fr[t / 16]);
          chk("stall_busy", bus.busy_o, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", bus.tx_o, 1'b1);
        chk("arst_busy", bus.busy_o, 1'b0);
        chk("arst_ready", bus.tx_ready_o, 1'b1);
        chk("arst_done", bus.tx_done_o, 1'b0);
        @(posedge clk); #1;
        chk("arst_done2", bus.tx_done_o, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_done", bus.tx_done_o, 1'b0);
        chk("post_rst_tx", bus.tx_o, 1'b1);
        return;
      end
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.ov_baud_rt_i = 1'b0;
    bus.data_i       = 8'h00;
    bus.data_width_i = 2'b11;
    bus.parity_en_i  = 1'b0;
    bus.parity_odd_i = 1'b0;
    bus.stop_bits_i  = 1'b0;
    bus.tx_valid_i   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", bus.tx_o, 1'b1);
    chk("rst_ready", bus.tx_ready_o, 1'b1);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.tx_done_o, 1'b0);
    rst_n = 1'b1;
    idle_cycles(3);

    // 8N1 0x55 at divisor 0, then 7E1 0xFF, then 5O2 0x03.
    run_frame(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
    idle_cycles(2);
    run_frame(8'hFF, 2'b10, 1'b1, 1'b0, 1'b0, 1, 0);
    idle_cycles(2);
    run_frame(8'h03, 2'b00, 1'b1, 1'b1, 1'b1, 0, 0);
    idle_cycles(2);

    // Back-to-back: second handshake lands in the tx_done_o cycle.
    run_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
    run_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 0, 0);
    idle_cycles(1);

    for (int n = 0; n < 10; n++) begin
      run_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3), 0);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the middle of the third data bit with ticks stalled, then a full frame.
    run_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b1, 1, 16 * 3 + 7);
    idle_cycles(2);
    run_frame(8'h96, 2'b11, 1'b1, 1'b0, 1'b1, 1, 0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
